// File: rtl/ram_text_writer_if.sv
// Byte-stream and RAM-port bundle for ram_text_writer.
// "master" is the producer/arbiter side; "slave" is the writer itself.
interface ram_text_writer_if #(
  parameter int AW = 10
);
  // A byte moves on a rising edge where char_valid && char_ready.
  // Once char_valid is raised, char_data holds until that edge.
  // A RAM write commits on a rising edge where ram_req && ram_grant (ram_we).
  // ram_addr and ram_din hold steady while ram_req stays high.
  logic          char_valid;
  logic [7:0]    char_data;
  logic          char_ready;
  logic          ram_grant;
  logic          ram_req;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_din;

  modport master (
    output char_valid, char_data, ram_grant,
    input  char_ready, ram_req, ram_we, ram_addr, ram_din
  );

  modport slave (
    input  char_valid, char_data, ram_grant,
    output char_ready, ram_req, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/ram_text_writer.sv
// Byte stream to character-RAM writer with auto-advancing cursor and newline.
// Defining RAM_TEXT_WRITER_CLEAR_EN adds the 8'h0C clear-screen sequence.
module ram_text_writer #(
  parameter int         COLS      = 32,
  parameter int         ROWS      = 32,
  parameter logic [7:0] CLEAR_VAL = 8'h00
) (
  input  logic                    clk,
  input  logic                    reset,
  ram_text_writer_if.slave        bus,
  output logic [$clog2(ROWS)-1:0] cursor_row,
  output logic [$clog2(COLS)-1:0] cursor_col,
  output logic                    busy,
  output logic [1:0]              state_dbg
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int AW = CW + RW;
  localparam logic [7:0] NEWLINE = 8'h0A;

`ifdef RAM_TEXT_WRITER_CLEAR_EN
  localparam logic [7:0] CLEAR_SCREEN = 8'h0C;
  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, CLEAR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1} state_t;
  // CLEAR_VAL only matters when the clear sequence is built.
  logic unused_clear_val;
  assign unused_clear_val = ^CLEAR_VAL;
`endif

  state_t        state_q, state_n;
  logic [RW-1:0] row_q, row_n;
  logic [CW-1:0] col_q, col_n;
  logic [AW-1:0] addr_q, addr_n;
  logic [7:0]    din_q, din_n;

  // addr_q doubles as the clear counter, so ram_addr/ram_din always come
  // straight from registers and stay stable across grant stalls.
  always_comb begin
    state_n = state_q;
    row_n   = row_q;
    col_n   = col_q;
    addr_n  = addr_q;
    din_n   = din_q;
    unique case (state_q)
      IDLE: begin
        if (bus.char_valid && bus.char_ready) begin
          if (bus.char_data == NEWLINE) begin
            col_n = '0;
            row_n = row_q + RW'(1);
          end
`ifdef RAM_TEXT_WRITER_CLEAR_EN
          else if (bus.char_data == CLEAR_SCREEN) begin
            state_n = CLEAR;
            addr_n  = '0;
            din_n   = CLEAR_VAL;
          end
`endif
          else begin
            state_n = WRITE;
            addr_n  = {row_q, col_q};
            din_n   = bus.char_data;
          end
        end
      end
      WRITE: begin
        if (bus.ram_grant) begin
          state_n        = IDLE;
          // Column carry ripples into the row; the row wraps with no scroll.
          {row_n, col_n} = {row_q, col_q} + AW'(1);
        end
      end
`ifdef RAM_TEXT_WRITER_CLEAR_EN
      CLEAR: begin
        if (bus.ram_grant) begin
          addr_n = addr_q + AW'(1);
          if (&addr_q) begin
            state_n = IDLE;
            row_n   = '0;
            col_n   = '0;
          end
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_n;
      row_q   <= row_n;
      col_q   <= col_n;
      addr_q  <= addr_n;
      din_q   <= din_n;
    end
  end

  // Gating with reset keeps a held-low reset from accepting or writing.
  assign bus.char_ready = reset && (state_q == IDLE);
  assign bus.ram_req    = reset && (state_q != IDLE);
  assign bus.ram_we     = bus.ram_req && bus.ram_grant;
  assign bus.ram_addr   = addr_q;
  assign bus.ram_din    = din_q;
  assign cursor_row     = row_q;
  assign cursor_col     = col_q;
  assign busy           = (state_q != IDLE);
  assign state_dbg      = state_q;
endmodule
